// File: rtl/dpe_partial_accum.sv
// Sums a stream of unsigned CSA_8 partial dot products, framed by in_last, into one
// ACC_WIDTH-bit result with a saturating beat count and a sticky carry-out flag.
module dpe_partial_accum #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = WIDTH + 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 ovf_reg;
    logic                 out_valid_reg;

    logic                 accept;
    logic                 start;
    logic [ACC_WIDTH:0]   sum_wide;

    // A held result frees the slot in the same cycle it is consumed, so a new
    // vector can start without a bubble.
    assign in_ready = (state_reg != HOLD) | out_ready;
    assign accept   = in_valid & in_ready;
    assign start    = accept & (state_reg != ACCUM);
    assign sum_wide = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(in_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next == HOLD);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = in_last ? HOLD : ACCUM;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (start) begin
            acc_reg <= ACC_WIDTH'(in_sum);
            cnt_reg <= CNT_W'(1);
            ovf_reg <= 1'b0;
        end else if (accept) begin
            acc_reg <= sum_wide[ACC_WIDTH-1:0];
            ovf_reg <= ovf_reg | sum_wide[ACC_WIDTH];
            if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = acc_reg;
    assign out_count = cnt_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_dpe_partial_accum.sv
// Drives one shared stimulus into a 24-bit and a 16-bit accumulator instance and
// checks both against a cycle model and a queue of expected results.
module tb_dpe_partial_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [23:0] out_sum;
    logic [7:0]  out_count;
    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_sum16;
    logic [7:0]  out_count16;

    always #5 clk = ~clk;

    dpe_partial_accum #(.WIDTH(16), .ACC_WIDTH(24), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    dpe_partial_accum #(.WIDTH(16), .ACC_WIDTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_sum(in_sum), .in_last(in_last), .out_valid(out_valid16),
        .out_ready(out_ready), .out_sum(out_sum16), .out_count(out_count16), .out_ovf(out_ovf16)
    );

    typedef struct {
        logic [23:0] s24;
        logic        o24;
        logic [15:0] s16;
        logic        o16;
        logic [7:0]  cnt;
    } res_t;

    typedef struct {
        int          beats;
        logic [15:0] val;
        logic [23:0] exp_sum;
        logic [15:0] exp_sum16;
        logic        exp_ovf16;
        logic [7:0]  exp_cnt;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    res_t        q[$];
    int          m_state = 0;   // 0 idle, 1 accumulating, 2 holding a result
    logic [23:0] m24 = '0;
    logic [15:0] m16 = '0;
    logic        mo24 = 1'b0;
    logic        mo16 = 1'b0;
    logic [7:0]  mcnt = '0;
    logic        fired = 1'b0;
    bit          rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic scoreboard();
        logic        exp_ir, accept;
        logic [24:0] t24;
        logic [16:0] t16;
        res_t        e;
        if (!rst_n) begin
            m_state = 0;
            q.delete();
            fired = 1'b0;
            return;
        end
        exp_ir = (m_state != 2) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("in_ready16", 32'(in_ready16), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(m_state == 2));
        chk("out_valid16", 32'(out_valid16), 32'(m_state == 2));
        fired  = in_valid && in_ready;
        accept = in_valid && exp_ir;
        if (m_state == 2 && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_result actual=0x%0h required=none", out_sum);
            end else begin
                e = q.pop_front();
                chk("sb_sum", 32'(out_sum), 32'(e.s24));
                chk("sb_ovf", 32'(out_ovf), 32'(e.o24));
                chk("sb_sum16", 32'(out_sum16), 32'(e.s16));
                chk("sb_ovf16", 32'(out_ovf16), 32'(e.o16));
                chk("sb_count", 32'(out_count), 32'(e.cnt));
                $display("result sum=0x%06h sum16=0x%04h ovf16=%0d count=%0d", e.s24, e.s16, e.o16, e.cnt);
            end
        end
        if (accept) begin
            if (m_state != 1) begin
                m24 = 24'(in_sum); m16 = in_sum; mo24 = 1'b0; mo16 = 1'b0; mcnt = 8'd1;
            end else begin
                t24 = {1'b0, m24} + 25'(in_sum);
                t16 = {1'b0, m16} + 17'(in_sum);
                m24 = t24[23:0]; mo24 = mo24 | t24[24];
                m16 = t16[15:0]; mo16 = mo16 | t16[16];
                if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
            end
            if (in_last) begin
                q.push_back('{s24: m24, o24: mo24, s16: m16, o16: mo16, cnt: mcnt});
                m_state = 2;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 2 && out_ready) begin
            m_state = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [15:0] v, input logic last);
        int n = 0;
        if (rand_mode) begin
            while ($urandom_range(0, 2) == 0) cycle();
        end
        in_valid = 1'b1;
        in_sum   = v;
        in_last  = last;
        do begin
            cycle();
            n++;
        end while (!fired && n < 1000);
        if (!fired) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sum   = 16'($urandom);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1,   16'h1234, 24'h001234, 16'h1234, 1'b0, 8'd1};
        vecs[1] = '{4,   16'hFFFF, 24'h03FFFC, 16'hFFFC, 1'b1, 8'd4};
        vecs[2] = '{2,   16'h8000, 24'h010000, 16'h0000, 1'b1, 8'd2};
        vecs[3] = '{3,   16'h0001, 24'h000003, 16'h0003, 1'b0, 8'd3};
        vecs[4] = '{1,   16'h0000, 24'h000000, 16'h0000, 1'b0, 8'd1};
        vecs[5] = '{300, 16'h0001, 24'h00012C, 16'h012C, 1'b0, 8'd255};

        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        chk("reset_out_ovf", 32'(out_ovf), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Table vectors, back to back with the consumer always ready.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            for (int b = 0; b < vecs[i].beats; b++) send_beat(vecs[i].val, b == vecs[i].beats - 1);
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            chk("tbl_out_sum", 32'(out_sum), 32'(vecs[i].exp_sum));
            chk("tbl_out_sum16", 32'(out_sum16), 32'(vecs[i].exp_sum16));
            chk("tbl_out_ovf16", 32'(out_ovf16), 32'(vecs[i].exp_ovf16));
            chk("tbl_out_count", 32'(out_count), 32'(vecs[i].exp_cnt));
            $display("vector %0d beats=%0d sum=0x%06h count=%0d", i, vecs[i].beats, out_sum, out_count);
        end
        cycle();
        chk("idle_after_consume", 32'(out_valid), 32'd0);

        // Wrap in the 16-bit instance sets ovf; the next vector clears it.
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0002, 1'b1);
        chk("wrap_sum16", 32'(out_sum16), 32'h0001);
        chk("wrap_ovf16", 32'(out_ovf16), 32'd1);
        chk("wrap_sum24", 32'(out_sum), 32'h010001);
        chk("wrap_ovf24", 32'(out_ovf), 32'd0);
        send_beat(16'h0005, 1'b1);
        chk("clear_sum16", 32'(out_sum16), 32'h0005);
        chk("clear_ovf16", 32'(out_ovf16), 32'd0);
        cycle();

        // Backpressure, then consume and accept in the same cycle.
        out_ready = 1'b0;
        send_beat(16'h0010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'h10);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        in_valid = 1'b1; in_sum = 16'h0007; in_last = 1'b1; out_ready = 1'b1;
        cycle();
        chk("bp_both_fire", 32'(fired), 32'd1);
        chk("bp_new_sum", 32'(out_sum), 32'h7);
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        cycle();

        // Asynchronous reset mid-vector discards the partial sum.
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0002, 1'b0);
        in_valid = 1'b1; in_sum = 16'h0003; in_last = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_sum", 32'(out_sum), 32'd0);
        chk("async_rst_out_count", 32'(out_count), 32'd0);
        in_valid = 1'b0; in_last = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        send_beat(16'h0009, 1'b1);
        chk("rel_out_sum", 32'(out_sum), 32'h9);
        chk("rel_out_count", 32'(out_count), 32'd1);
        cycle();

        // Random vectors with input gaps and consumer stalls.
        rand_mode = 1'b1;
        for (int v = 0; v < 200; v++) begin
            int nb;
            nb = $urandom_range(1, 20);
            for (int b = 0; b < nb; b++) send_beat(16'($urandom), b == nb - 1);
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
